// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle control unit.
// Optional feature: MC_JAL_EN adds the JAL state (jump-and-link support).
package mc_ctrl_pkg;

    // Controller states; JAL only exists when jump support is built in
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWRITE = 4'd4,
        S_MEMWB    = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
`ifdef MC_JAL_EN
        S_ILLEGAL  = 4'd10,
        S_JAL      = 4'd11
`else
        S_ILLEGAL  = 4'd10
`endif
    } state_t;

    // Opcodes recognised by the decoder (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Writeback / PC result select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Bundle of every control output driven by the decoder
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       branch;
        logic       illegal;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state-to-control decode for the multicycle controller.
// Optional feature: MC_JAL_EN adds decode for the JAL state.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic       zero,
    output ctrl_t      ctrl
);

    // Drive the control word for the current state; anything not set stays 0
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURESULT;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_write   = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.adr_src   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_MEMDATA;
                ctrl.reg_write  = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.pc_write   = zero;
            end
            S_ILLEGAL: begin
                ctrl.illegal = 1'b1;
            end
`ifdef MC_JAL_EN
            S_JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = 1'b1;
            end
`endif
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control unit: state register, next-state logic
// and retired-instruction counter; outputs come from mc_ctrl_outdec.
// Optional feature: MC_JAL_EN enables the JAL instruction path.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             branch,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic             retire;
    ctrl_t            dec_ctrl;
    ctrl_t            ctrl;

    // State register; reset wins over any pending transition or memory wait
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection from the current state, opcode and memory handshake
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BEQ;
`ifdef MC_JAL_EN
                    OP_JAL:            next_state = S_JAL;
`endif
                    default:           next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
            S_MEMWB:    next_state = S_FETCH;
            S_EXECR:    next_state = S_ALUWB;
            S_EXECI:    next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BEQ:      next_state = S_FETCH;
            S_ILLEGAL:  next_state = S_ILLEGAL;
`ifdef MC_JAL_EN
            S_JAL:      next_state = S_ALUWB;
`endif
            default:    next_state = S_ILLEGAL;
        endcase
    end

    // An instruction retires on the edge that returns the FSM to FETCH
    always_comb begin
        retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                 ((state == S_MEMWRITE) && mem_ready);
    end

    // Retired-instruction counter, wrapping naturally at its width
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (retire) begin
            count <= count + CNT_W'(1);
        end
    end

    mc_ctrl_outdec u_outdec (
        .state     (state),
        .mem_ready (mem_ready),
        .zero      (zero),
        .ctrl      (dec_ctrl)
    );

    // Hold every output at 0 while reset is asserted, even before the first edge
    always_comb begin
        ctrl    = rst ? '0 : dec_ctrl;
        instret = rst ? '0 : count;
    end

    assign mem_req    = ctrl.mem_req;
    assign mem_write  = ctrl.mem_write;
    assign adr_src    = ctrl.adr_src;
    assign ir_write   = ctrl.ir_write;
    assign pc_write   = ctrl.pc_write;
    assign reg_write  = ctrl.reg_write;
    assign branch     = ctrl.branch;
    assign illegal    = ctrl.illegal;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign result_src = ctrl.result_src;

endmodule
